// File: rtl/uart_bridge_pkg.sv
// Shared constants, state encodings and small helpers for the UART-to-Wishbone bridge.
package uart_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] RSP_OK    = 8'hA5;
    localparam logic [7:0] RSP_ERR   = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_BUS  = 3'd3,
        ST_RESP = 3'd4
    } bridge_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_ISSUE = 2'd1,
        TX_GAP   = 2'd2,
        TX_DRAIN = 2'd3
    } tx_state_e;

    // True for the two opcodes the bridge understands.
    function automatic logic is_known_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

    // Byte i of a little-endian 32-bit word.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        logic [7:0] r;
        case (i)
            2'd0:    r = w[7:0];
            2'd1:    r = w[15:8];
            2'd2:    r = w[23:16];
            2'd3:    r = w[31:24];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/async_receiver.sv
// Serial byte receiver: 8N1, mid-bit sampling, data held until RxD_clear.
module async_receiver #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       RxD,
    input  logic       RxD_clear,
    output logic       RxD_data_ready,
    output logic [7:0] RxD_data
);

    localparam int         CLKS      = CLK_FREQ / BAUD;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e   state_r;
    logic        rxd_meta_r;
    logic        rxd_sync_r;
    logic [15:0] cnt_r;
    logic [2:0]  bits_r;
    logic [7:0]  shift_r;
    logic [7:0]  data_r;
    logic        ready_r;

    assign RxD_data_ready = ready_r;
    assign RxD_data       = data_r;

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
        end else begin
            rxd_meta_r <= RxD;
            rxd_sync_r <= rxd_meta_r;
        end
    end

    // Frame receiver: find start edge, sample each bit mid-period, check stop bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= RX_IDLE;
            cnt_r   <= 16'd0;
            bits_r  <= 3'd0;
            shift_r <= 8'h00;
            data_r  <= 8'h00;
            ready_r <= 1'b0;
        end else begin
            if (RxD_clear) begin
                ready_r <= 1'b0;
            end
            case (state_r)
                RX_IDLE: begin
                    cnt_r <= 16'd0;
                    if (!rxd_sync_r) begin
                        state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r <= 16'd0;
                        bits_r <= 3'd0;
                        state_r <= rxd_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= 16'd0;
                        shift_r <= {rxd_sync_r, shift_r[7:1]};
                        if (bits_r == 3'd7) begin
                            state_r <= RX_STOP;
                        end else begin
                            bits_r <= bits_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= 16'd0;
                        state_r <= RX_IDLE;
                        if (rxd_sync_r) begin
                            data_r  <= shift_r;
                            ready_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: state_r <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/async_transmitter.sv
// Serial byte transmitter: 8N1; TxD_busy rises the cycle after TxD_start is accepted.
module async_transmitter #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD,
    output logic       TxD_busy
);

    localparam int          CLKS     = CLK_FREQ / BAUD;
    localparam logic [15:0] BIT_LAST = 16'(CLKS - 1);

    logic        txd_r;
    logic        busy_r;
    logic [8:0]  shift_r;
    logic [15:0] cnt_r;
    logic [3:0]  bits_r;

    assign TxD      = txd_r;
    assign TxD_busy = busy_r;

    // Shift out start bit, 8 data bits LSB first, then the stop bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            txd_r   <= 1'b1;
            busy_r  <= 1'b0;
            shift_r <= 9'h1FF;
            cnt_r   <= 16'd0;
            bits_r  <= 4'd0;
        end else if (!busy_r) begin
            if (TxD_start) begin
                txd_r   <= 1'b0;
                shift_r <= {1'b1, TxD_data};
                cnt_r   <= 16'd0;
                bits_r  <= 4'd0;
                busy_r  <= 1'b1;
            end else begin
                txd_r <= 1'b1;
            end
        end else if (cnt_r == BIT_LAST) begin
            cnt_r <= 16'd0;
            if (bits_r == 4'd9) begin
                busy_r <= 1'b0;
            end else begin
                txd_r   <= shift_r[0];
                shift_r <= {1'b1, shift_r[8:1]};
                bits_r  <= bits_r + 4'd1;
            end
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

endmodule

// File: rtl/uart_bridge_tx_ser.sv
// Response serialiser: feeds a 1- or 4-byte buffer to the UART transmitter.
module uart_bridge_tx_ser
    import uart_bridge_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        go_i,
    input  logic [31:0] buf_i,
    input  logic [2:0]  len_i,
    input  logic        tx_busy_i,
    output logic        tx_start_o,
    output logic [7:0]  tx_data_o,
    output logic        done_o
);

    tx_state_e   state_r;
    logic [31:0] buf_r;
    logic [1:0]  last_r;
    logic [1:0]  idx_r;
    logic        start_r;
    logic [7:0]  data_r;
    logic        done_r;

    assign tx_start_o = start_r;
    assign tx_data_o  = data_r;
    assign done_o     = done_r;

    // Issue a start only while the transmitter is idle, then skip one cycle
    // so its busy flag has time to assert before it is sampled again.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= TX_IDLE;
            buf_r   <= 32'h0;
            last_r  <= 2'd0;
            idx_r   <= 2'd0;
            start_r <= 1'b0;
            data_r  <= 8'h00;
            done_r  <= 1'b0;
        end else begin
            start_r <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                TX_IDLE: begin
                    if (go_i) begin
                        buf_r  <= buf_i;
                        last_r <= 2'(len_i - 3'd1);
                        idx_r  <= 2'd0;
                        if (!tx_busy_i) begin
                            start_r <= 1'b1;
                            data_r  <= buf_i[7:0];
                            state_r <= TX_GAP;
                        end else begin
                            state_r <= TX_ISSUE;
                        end
                    end
                end
                TX_ISSUE: begin
                    if (!tx_busy_i) begin
                        start_r <= 1'b1;
                        data_r  <= byte_of(buf_r, idx_r);
                        state_r <= TX_GAP;
                    end
                end
                TX_GAP: begin
                    state_r <= TX_DRAIN;
                end
                TX_DRAIN: begin
                    if (!tx_busy_i) begin
                        if (idx_r == last_r) begin
                            done_r  <= 1'b1;
                            state_r <= TX_IDLE;
                        end else begin
                            idx_r   <= idx_r + 2'd1;
                            start_r <= 1'b1;
                            data_r  <= byte_of(buf_r, idx_r + 2'd1);
                            state_r <= TX_GAP;
                        end
                    end
                end
                default: state_r <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_wb_bridge.sv
// UART-to-Wishbone debug bridge: byte commands in, single Wishbone transfer, byte reply out.
module uart_wb_bridge
    import uart_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int BUS_TIMEOUT  = 1024,
    parameter int BYTE_TIMEOUT = 65536
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    uart_rxd_i,
    output logic                    uart_txd_o,
    output logic                    busy_o
);

    localparam int BUS_CNT_W  = $clog2(BUS_TIMEOUT + 1);
    localparam int BYTE_CNT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [BUS_CNT_W-1:0]  BUS_LAST = BUS_CNT_W'(BUS_TIMEOUT - 1);
    localparam logic [BYTE_CNT_W-1:0] BYTE_MAX = BYTE_CNT_W'(BYTE_TIMEOUT);

    bridge_state_e           state_r;
    logic                    op_write_r;
    logic [1:0]              cnt_r;
    logic [31:0]             addr_sh_r;
    logic [31:0]             data_sh_r;
    logic [31:0]             addr_next_s;
    logic [31:0]             data_next_s;
    logic                    cyc_r;
    logic                    stb_r;
    logic                    we_r;
    logic [ADDR_WIDTH-1:0]   adr_r;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic [DATA_WIDTH/8-1:0] sel_r;
    logic                    busy_r;
    logic [BUS_CNT_W-1:0]    bus_cnt_r;
    logic [BYTE_CNT_W-1:0]   byte_cnt_r;
    logic [31:0]             resp_buf_r;
    logic [2:0]              resp_len_r;
    logic                    ser_go_r;
    logic                    ser_done_s;
    logic                    rx_ready_s;
    logic [7:0]              rx_data_s;
    logic                    rx_clear_r;
    logic                    byte_vld_s;
    logic                    tx_start_s;
    logic [7:0]              tx_data_s;
    logic                    tx_busy_s;

    // data_ready stays high during the clear cycle, so mask it to count each byte once.
    assign byte_vld_s  = rx_ready_s & ~rx_clear_r;
    assign addr_next_s = {rx_data_s, addr_sh_r[31:8]};
    assign data_next_s = {rx_data_s, data_sh_r[31:8]};

    assign wb_cyc_o = cyc_r;
    assign wb_stb_o = stb_r;
    assign wb_we_o  = we_r;
    assign wb_adr_o = adr_r;
    assign wb_dat_o = dat_r;
    assign wb_sel_o = sel_r;
    assign busy_o   = busy_r;

    async_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .RxD            (uart_rxd_i),
        .RxD_clear      (rx_clear_r),
        .RxD_data_ready (rx_ready_s),
        .RxD_data       (rx_data_s)
    );

    async_transmitter #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tx (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .TxD_start (tx_start_s),
        .TxD_data  (tx_data_s),
        .TxD       (uart_txd_o),
        .TxD_busy  (tx_busy_s)
    );

    uart_bridge_tx_ser u_ser (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .go_i       (ser_go_r),
        .buf_i      (resp_buf_r),
        .len_i      (resp_len_r),
        .tx_busy_i  (tx_busy_s),
        .tx_start_o (tx_start_s),
        .tx_data_o  (tx_data_s),
        .done_o     (ser_done_s)
    );

    // Inter-byte idle counter: cleared by every captured byte, saturates at the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt_r <= '0;
        end else if (byte_vld_s) begin
            byte_cnt_r <= '0;
        end else if (byte_cnt_r != BYTE_MAX) begin
            byte_cnt_r <= byte_cnt_r + BYTE_CNT_W'(1);
        end
    end

    // Command FSM with registered Wishbone, busy and serialiser controls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_IDLE;
            op_write_r <= 1'b0;
            cnt_r      <= 2'd0;
            addr_sh_r  <= 32'h0;
            data_sh_r  <= 32'h0;
            cyc_r      <= 1'b0;
            stb_r      <= 1'b0;
            we_r       <= 1'b0;
            adr_r      <= '0;
            dat_r      <= '0;
            sel_r      <= '0;
            busy_r     <= 1'b0;
            bus_cnt_r  <= '0;
            resp_buf_r <= 32'h0;
            resp_len_r <= 3'd1;
            ser_go_r   <= 1'b0;
            rx_clear_r <= 1'b0;
        end else begin
            rx_clear_r <= byte_vld_s;
            ser_go_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (byte_vld_s) begin
                        busy_r <= 1'b1;
                        if (is_known_cmd(rx_data_s)) begin
                            op_write_r <= (rx_data_s == CMD_WRITE);
                            cnt_r      <= 2'd0;
                            state_r    <= ST_ADDR;
                        end else begin
                            resp_buf_r <= {24'h0, RSP_ERR};
                            resp_len_r <= 3'd1;
                            ser_go_r   <= 1'b1;
                            state_r    <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (byte_vld_s) begin
                        addr_sh_r <= addr_next_s;
                        cnt_r     <= cnt_r + 2'd1;
                        if (cnt_r == 2'd3) begin
                            if (op_write_r) begin
                                state_r <= ST_DATA;
                            end else begin
                                cyc_r     <= 1'b1;
                                stb_r     <= 1'b1;
                                we_r      <= 1'b0;
                                sel_r     <= '1;
                                adr_r     <= ADDR_WIDTH'(addr_next_s);
                                dat_r     <= '0;
                                bus_cnt_r <= '0;
                                state_r   <= ST_BUS;
                            end
                        end
                    end else if (byte_cnt_r == BYTE_MAX) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (byte_vld_s) begin
                        data_sh_r <= data_next_s;
                        cnt_r     <= cnt_r + 2'd1;
                        if (cnt_r == 2'd3) begin
                            cyc_r     <= 1'b1;
                            stb_r     <= 1'b1;
                            we_r      <= 1'b1;
                            sel_r     <= '1;
                            adr_r     <= ADDR_WIDTH'(addr_sh_r);
                            dat_r     <= DATA_WIDTH'(data_next_s);
                            bus_cnt_r <= '0;
                            state_r   <= ST_BUS;
                        end
                    end else if (byte_cnt_r == BYTE_MAX) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUS: begin
                    // Ack wins over a timeout expiring in the same cycle.
                    if (wb_ack_i) begin
                        cyc_r    <= 1'b0;
                        stb_r    <= 1'b0;
                        we_r     <= 1'b0;
                        sel_r    <= '0;
                        ser_go_r <= 1'b1;
                        state_r  <= ST_RESP;
                        if (we_r) begin
                            resp_buf_r <= {24'h0, RSP_OK};
                            resp_len_r <= 3'd1;
                        end else begin
                            resp_buf_r <= 32'(wb_dat_i);
                            resp_len_r <= 3'd4;
                        end
                    end else if (bus_cnt_r == BUS_LAST) begin
                        cyc_r      <= 1'b0;
                        stb_r      <= 1'b0;
                        we_r       <= 1'b0;
                        sel_r      <= '0;
                        resp_buf_r <= {24'h0, RSP_ERR};
                        resp_len_r <= 3'd1;
                        ser_go_r   <= 1'b1;
                        state_r    <= ST_RESP;
                    end else begin
                        bus_cnt_r <= bus_cnt_r + BUS_CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (ser_done_s) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    cyc_r   <= 1'b0;
                    stb_r   <= 1'b0;
                    we_r    <= 1'b0;
                    sel_r   <= '0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Scoreboard bench for uart_wb_bridge: UART driver, Wishbone memory slave, UART reply monitor.
module tb_uart_wb_bridge;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int BUS_TO   = 16;
    localparam int BYTE_TO  = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc, wb_stb, wb_we, wb_ack;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel;
    logic        rxd = 1'b1;
    logic        txd, busy;

    always #5 clk = ~clk;

    uart_wb_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD),
        .BUS_TIMEOUT(BUS_TO), .BYTE_TIMEOUT(BYTE_TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack),
        .uart_rxd_i(rxd), .uart_txd_o(txd), .busy_o(busy)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        bit          timeout;
        bit          abort;
    } wb_exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc_cnt = 0;
    int          ack_at = 0;
    bit          lat_pend = 1'b0;
    int          slave_waits = 0;
    bit          slave_noack = 1'b0;
    wb_exp_t     wb_q[$];
    logic [7:0]  rsp_q[$];
    logic [7:0]  cmd_q[$];
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] slave_mem[logic [31:0]];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: decode the command bytes and queue the expected bus transfer and reply.
    task automatic predict(input bit noack);
        wb_exp_t     e;
        logic [31:0] a, d;
        logic [7:0]  op;
        op = cmd_q[0];
        if (op != 8'h01 && op != 8'h02) begin
            rsp_q.push_back(8'hEE);
        end else if ((op == 8'h01 && cmd_q.size() >= 9) || (op == 8'h02 && cmd_q.size() >= 5)) begin
            a = {cmd_q[4], cmd_q[3], cmd_q[2], cmd_q[1]};
            d = (op == 8'h01) ? {cmd_q[8], cmd_q[7], cmd_q[6], cmd_q[5]} : 32'h0;
            e = '{adr: a, dat: d, we: (op == 8'h01), timeout: noack, abort: 1'b0};
            wb_q.push_back(e);
            if (noack) begin
                rsp_q.push_back(8'hEE);
            end else if (op == 8'h01) begin
                model_mem[a] = d;
                rsp_q.push_back(8'hA5);
            end else begin
                d = model_mem.exists(a) ? model_mem[a] : ~a;
                for (int i = 0; i < 4; i++) rsp_q.push_back(8'((d >> (8 * i)) & 32'hFF));
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk) rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (BIT + $urandom_range(0, 8)) @(negedge clk);
    endtask

    task automatic send_cmd();
        for (int i = 0; i < cmd_q.size(); i++) send_byte(cmd_q[i]);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (n < 20000 && !(rsp_q.size() == 0 && wb_q.size() == 0 && !busy)) begin
            @(negedge clk);
            n++;
        end
        check({name, "_complete"}, (n < 20000), 1'b1);
        if (n >= 20000) begin
            rsp_q.delete();
            wb_q.delete();
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic run_cmd(input string name, input int waits, input bit noack);
        slave_waits = waits;
        slave_noack = noack;
        predict(noack);
        send_cmd();
        wait_done(name);
        slave_noack = 1'b0;
    endtask

    // Wishbone slave and bus monitor: memory behind the bus, checks each transfer against the queue.
    initial begin : slave
        int      wcnt, len;
        bit      active, acked;
        wb_exp_t cur;
        wcnt = 0; len = 0; active = 0; acked = 0;
        cur = '{adr: 32'h0, dat: 32'h0, we: 1'b0, timeout: 1'b0, abort: 1'b1};
        wb_ack = 1'b0;
        wb_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            wb_ack = 1'b0;
            if (active && acked) begin
                check("wb_cyc_drop_after_ack", {wb_cyc, wb_stb}, 2'b00);
                active = 0;
                acked = 0;
            end else if (wb_cyc && wb_stb) begin
                if (!active) begin
                    active = 1; len = 0; wcnt = 0;
                    if (wb_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL wb_unexpected_cycle got adr=%h expected no cycle", wb_adr);
                        cur = '{adr: wb_adr, dat: 32'h0, we: 1'b0, timeout: 1'b0, abort: 1'b1};
                    end else begin
                        cur = wb_q.pop_front();
                        check("wb_adr", wb_adr, cur.adr);
                        check("wb_we", wb_we, cur.we);
                        check("wb_sel", wb_sel, 4'hF);
                        if (cur.we) check("wb_dat", wb_dat_o, cur.dat);
                    end
                end else begin
                    check("wb_adr_hold", wb_adr, cur.adr);
                end
                len++;
                if (!slave_noack) begin
                    if (wcnt == slave_waits) begin
                        wb_ack = 1'b1;
                        acked = 1;
                        wb_dat_i = slave_mem.exists(wb_adr) ? slave_mem[wb_adr] : ~wb_adr;
                        if (wb_we) slave_mem[wb_adr] = wb_dat_o;
                        ack_at = cyc_cnt;
                        lat_pend = 1'b1;
                    end else begin
                        wcnt++;
                    end
                end
            end else if (active) begin
                if (cur.timeout) check("wb_timeout_cycles", len, BUS_TO);
                else if (!cur.abort) begin
                    total++; bad++;
                    $display("FAIL wb_dropped_without_ack got len=%0d expected ack", len);
                end
                active = 0;
            end
        end
    end

    // UART reply monitor: decodes bytes from txd and compares against the expected reply queue.
    initial begin : txmon
        logic [7:0] b;
        int         st;
        forever begin
            @(posedge clk); #1;
            if (rst_n && txd === 1'b0) begin
                st = cyc_cnt;
                if (lat_pend) begin
                    lat_pend = 1'b0;
                    check("ack_to_start_latency_le3", ((st - ack_at - 1) <= 3), 1'b1);
                end
                repeat (BIT / 2) @(posedge clk); #1;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(posedge clk); #1;
                    b[i] = txd;
                end
                repeat (BIT) @(posedge clk); #1;
                check("tx_stop_bit", txd, 1'b1);
                if (rsp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_unexpected_byte got=%h expected none", b);
                end else begin
                    check("tx_byte", b, rsp_q.pop_front());
                end
            end
        end
    end

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 4))
            0: return 32'h0000_0000;
            1: return 32'h0000_0004;
            2: return 32'h8000_0010;
            3: return 32'h1000_0100;
            default: return $urandom;
        endcase
    endfunction

    initial begin : stim
        logic [31:0] a, d;
        int          n;
        model_mem[32'h1000_0100] = 32'h1234_5678;
        slave_mem[32'h1000_0100] = 32'h1234_5678;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cyc", wb_cyc, 1'b0);
        check("rst_stb", wb_stb, 1'b0);
        check("rst_we", wb_we, 1'b0);
        check("rst_adr", wb_adr, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_sel", wb_sel, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_txd", txd, 1'b1);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Write
        cmd_q = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_cmd("write", 2, 1'b0);

        // Read with 5 wait states
        cmd_q = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h10};
        run_cmd("read", 5, 1'b0);

        // Bus timeout, then a valid read of the earlier write
        cmd_q = '{8'h02, 8'h44, 8'h33, 8'h22, 8'h11};
        run_cmd("bus_timeout", 0, 1'b1);
        cmd_q = '{8'h02, 8'h10, 8'h00, 8'h00, 8'h80};
        run_cmd("read_after_timeout", 1, 1'b0);

        // Bad opcode
        cmd_q = '{8'h7F};
        run_cmd("bad_opcode", 0, 1'b0);

        // Partial command abandoned by the byte timeout
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h00);
        repeat (BYTE_TO + 500) @(negedge clk);
        check("partial_back_to_idle", busy, 1'b0);
        cmd_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
        run_cmd("read_after_partial", 3, 1'b0);

        // Randomised command mix
        for (int k = 0; k < 14; k++) begin
            n = $urandom_range(0, 9);
            a = pick_addr();
            d = $urandom;
            if (n == 0) begin
                cmd_q = '{8'($urandom_range(3, 255))};
            end else if (n <= 5) begin
                cmd_q = '{8'h01, a[7:0], a[15:8], a[23:16], a[31:24],
                          d[7:0], d[15:8], d[23:16], d[31:24]};
            end else begin
                cmd_q = '{8'h02, a[7:0], a[15:8], a[23:16], a[31:24]};
            end
            run_cmd("random", $urandom_range(0, 6), (n == 1 || n == 9));
        end

        // Reset in the middle of a bus cycle
        slave_noack = 1'b1;
        wb_q.push_back('{adr: 32'h0000_0004, dat: 32'h0, we: 1'b0, timeout: 1'b0, abort: 1'b1});
        cmd_q = '{8'h02, 8'h04, 8'h00, 8'h00, 8'h00};
        send_cmd();
        n = 0;
        while (n < 5000 && !wb_cyc) begin
            @(negedge clk);
            n++;
        end
        check("reset_test_cycle_started", wb_cyc, 1'b1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_mid_cyc", wb_cyc, 1'b0);
        check("reset_mid_stb", wb_stb, 1'b0);
        check("reset_mid_txd", txd, 1'b1);
        check("reset_mid_busy", busy, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        slave_noack = 1'b0;
        repeat (400) @(negedge clk);
        check("reset_no_pending_wb", wb_q.size(), 0);
        check("reset_txd_idle", txd, 1'b1);

        // Bridge works again after reset
        cmd_q = '{8'h02, 8'h10, 8'h00, 8'h00, 8'h80};
        run_cmd("read_after_reset", 2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
